rx_addr_filter: RTL and testbench
=================================

# rx_addr_filter

Parametrised receive destination-address filter for the 10G MAC RX engine. It classifies each frame's 48-bit destination address against a programmable table of unicast entries, broadcast, the PAUSE control multicast, a 64-bin multicast hash and promiscuous mode, and issues one accept/drop verdict per frame. The verdict and match class go to the RX frame controller. A saturating drop counter is exported to the statistics block.

## Interface
Parameters:
- NUM_UCAST, 4: number of programmable unicast entries (1..16).
- CNT_W, 32: drop-counter width.
- PAUSE_ADDR, 48'h0180C2000001: MAC-control multicast, always accepted when PAUSE_EN=1.
- PAUSE_EN, 1: enables the PAUSE address class.

Ports:
- rxclk, in, 1: RX clock. All logic is on the rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- cfg_we, in, 1: write strobe for a unicast table entry.
- cfg_idx, in, max(1,$clog2(NUM_UCAST)): entry index for cfg_we.
- cfg_addr, in, 48: address written to the entry.
- cfg_ent_en, in, 1: valid bit written with the entry.
- cfg_promisc, in, 1: accept all frames.
- cfg_bcast_en, in, 1: accept broadcast.
- cfg_mcast_all, in, 1: accept every multicast.
- hash_table, in, 64: multicast hash bins; static configuration.
- cnt_clr, in, 1: synchronous clear of drop_count.
- da_valid, in, 1: one-cycle pulse per frame, qualifies da_addr.
- da_addr, in, 48: destination address. First octet is in [47:40]; the I/G bit is [40].
- res_valid, out, 1: one-cycle verdict pulse.
- res_accept, out, 1: frame accepted. Valid with res_valid.
- res_class, out, 3: match class. Valid with res_valid.
- res_idx, out, max(1,$clog2(NUM_UCAST)): matching unicast entry. Valid when res_class=UCAST.
- drop_count, out, CNT_W: saturating count of dropped frames.

## Operation
- Table: NUM_UCAST entries, each a 48-bit address plus a valid bit.
  - Entry cfg_idx is written on cfg_we. The write is visible to compares starting in the next cycle.
  - If cfg_idx >= NUM_UCAST, the write is ignored.
- Hash index: XOR-fold of da_addr into 6 bits, computed as da_addr[5:0] ^ [11:6] ^ … ^ [47:42].
- Classes: NONE=0, UCAST=1, BCAST=2, PAUSE=3, MCAST_HASH=4, MCAST_ALL=5, PROMISC=6.
- Class priority, first true wins:
  - BCAST: all-ones address and cfg_bcast_en.
  - PAUSE: da_addr==PAUSE_ADDR and PAUSE_EN.
  - UCAST: a valid entry equals da_addr. The lowest matching index is reported.
  - MCAST_HASH: da_addr[40] and hash_table[index].
  - MCAST_ALL: da_addr[40] and cfg_mcast_all.
  - PROMISC: cfg_promisc.
  - Otherwise NONE.
- Broadcast with cfg_bcast_en=0 falls through the list. It can still match MCAST_HASH, MCAST_ALL or PROMISC.
- res_accept = (res_class != NONE).
- drop_count:
  - Increments on res_valid & ~res_accept and saturates at all-ones.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.

## Timing
- Two-stage pipeline, fully pipelined. da_valid may assert every cycle with no stall.
- Stage 1, edge after da_valid: registers the UCAST match vector, the bcast/pause/mcast/hash flags, and a valid bit. Table contents are sampled at this edge.
- Stage 2: registers the priority decision.
- Latency: da_valid in cycle N gives res_valid in cycle N+2.
- drop_count reflects the verdict from cycle N+3.
- cfg_we to the matching entry in the same cycle as da_valid: the compare uses the old entry contents.
- Configuration levels (cfg_promisc, cfg_bcast_en, cfg_mcast_all, hash_table) are sampled at stage 1.
- Reset values: res_valid=0, res_accept=0, res_class=0, res_idx=0, drop_count=0.
  - All table entries are invalid with address 0.
  - Both pipeline valid bits are cleared.
- Reset asserted mid-operation discards in-flight verdicts. No res_valid is produced for them after release.

## Structure
- Shared package rx_filter_pkg holds:
  - the class encoding constants;
  - the broadcast constant;
  - the hash-fold function.
- Sub-module rx_ucast_table: the register array, write port and parallel compare. It outputs a NUM_UCAST match vector.
- The top level holds the flag logic, priority encoder, pipeline registers and drop counter.

## Test plan
- Unicast: program entry 2 = 00_1B_21_3A_4C_5D, valid. Send that DA → at N+2, res_valid=1, accept=1, class=1, idx=2. An unprogrammed DA → class=0, drop_count=1.
- Broadcast: cfg_bcast_en=1, DA FFFF_FFFF_FFFF → class=2. Repeat with bcast_en=0, promisc=0, hash=0 → class=0.
- PAUSE and hash:
  - DA 0180C2000001 → class=3.
  - DA 01005E000001 with only its hash bin set → class=4.
  - Same DA with bin clear and cfg_mcast_all=1 → class=5.
- Back-to-back:
  - Three da_valid pulses in consecutive cycles → three res_valid pulses in consecutive cycles, in order, with correct classes.
  - cfg_we overwriting the matched entry in the same cycle as da_valid → old match result.
- Counter: force 2^CNT_W+3 drops with CNT_W=4 → drop_count saturates at 15. cnt_clr coincident with a drop → 0.
- Reset: assert reset_n low one cycle after da_valid → no res_valid follows, all outputs 0, table invalid.

Source files
------------

// File: rtl/rx_addr_filter_pkg.sv
// Shared definitions for the RX destination-address filter: match classes,
// broadcast constant, multicast hash fold and index-width helper.
package rx_filter_pkg;

  typedef enum logic [2:0] {
    CLS_NONE       = 3'd0,
    CLS_UCAST      = 3'd1,
    CLS_BCAST      = 3'd2,
    CLS_PAUSE      = 3'd3,
    CLS_MCAST_HASH = 3'd4,
    CLS_MCAST_ALL  = 3'd5,
    CLS_PROMISC    = 3'd6
  } match_class_e;

  localparam logic [47:0] BCAST_ADDR = '1;

  // 6-bit hash: XOR of the eight 6-bit slices of the address
  function automatic logic [5:0] hash_fold(input logic [47:0] addr);
    logic [5:0] h;
    h = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      h ^= addr[i*6 +: 6];
    end
    return h;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_addr_filter_if.sv
// Per-frame handshake: destination address in, one-cycle verdict out.
interface rx_addr_filter_if #(
  parameter int IDX_W = 2
);
  logic             da_valid;
  logic [47:0]      da_addr;
  logic             res_valid;
  logic             res_accept;
  logic [2:0]       res_class;
  logic [IDX_W-1:0] res_idx;

  modport master (
    output da_valid, da_addr,
    input  res_valid, res_accept, res_class, res_idx
  );

  modport slave (
    input  da_valid, da_addr,
    output res_valid, res_accept, res_class, res_idx
  );
endinterface

// File: rtl/rx_addr_filter_ucast.sv
// Unicast entry table: register array with a single write port and a
// parallel compare of every valid entry against the incoming address.
module rx_ucast_table
  import rx_filter_pkg::*;
#(
  parameter int NUM_UCAST = 4
) (
  input  logic                              rxclk,
  input  logic                              reset_n,
  input  logic                              cfg_we_i,
  input  logic [idx_width(NUM_UCAST)-1:0]   cfg_idx_i,
  input  logic [47:0]                       cfg_addr_i,
  input  logic                              cfg_ent_en_i,
  input  logic [47:0]                       da_addr_i,
  output logic [NUM_UCAST-1:0]              match_o
);

  logic [47:0]          addr_q [NUM_UCAST];
  logic [NUM_UCAST-1:0] en_q;

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_UCAST; i++) begin
        addr_q[i] <= '0;
      end
      en_q <= '0;
    end else if (cfg_we_i && (int'(cfg_idx_i) < NUM_UCAST)) begin
      addr_q[cfg_idx_i] <= cfg_addr_i;
      en_q[cfg_idx_i]   <= cfg_ent_en_i;
    end
  end

  // Compares read the registered table, so a same-cycle write is not seen
  always_comb begin
    match_o = '0;
    for (int unsigned i = 0; i < NUM_UCAST; i++) begin
      match_o[i] = en_q[i] && (addr_q[i] == da_addr_i);
    end
  end

endmodule

// File: rtl/rx_addr_filter.sv
// RX destination-address filter: two-stage pipeline producing one
// accept/drop verdict and match class per frame, plus a saturating drop count.
module rx_addr_filter
  import rx_filter_pkg::*;
#(
  parameter int          NUM_UCAST  = 4,
  parameter int          CNT_W      = 32,
  parameter logic [47:0] PAUSE_ADDR = 48'h0180C2000001,
  parameter bit          PAUSE_EN   = 1'b1
) (
  input  logic                            rxclk,
  input  logic                            reset_n,
  input  logic                            cfg_we,
  input  logic [idx_width(NUM_UCAST)-1:0] cfg_idx,
  input  logic [47:0]                     cfg_addr,
  input  logic                            cfg_ent_en,
  input  logic                            cfg_promisc,
  input  logic                            cfg_bcast_en,
  input  logic                            cfg_mcast_all,
  input  logic [63:0]                     hash_table,
  input  logic                            cnt_clr,
  rx_addr_filter_if.slave                 fif,
  output logic [CNT_W-1:0]                drop_count
);

  localparam int IDX_W = idx_width(NUM_UCAST);

  logic [NUM_UCAST-1:0] match;

  rx_ucast_table #(.NUM_UCAST(NUM_UCAST)) u_table (
    .rxclk        (rxclk),
    .reset_n      (reset_n),
    .cfg_we_i     (cfg_we),
    .cfg_idx_i    (cfg_idx),
    .cfg_addr_i   (cfg_addr),
    .cfg_ent_en_i (cfg_ent_en),
    .da_addr_i    (fif.da_addr),
    .match_o      (match)
  );

  // Stage 1: match vector and class flags
  logic                 v1_q;
  logic [NUM_UCAST-1:0] match1_q;
  logic                 bcast1_q, pause1_q, hash1_q, mall1_q, prom1_q;

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q     <= 1'b0;
      match1_q <= '0;
      bcast1_q <= 1'b0;
      pause1_q <= 1'b0;
      hash1_q  <= 1'b0;
      mall1_q  <= 1'b0;
      prom1_q  <= 1'b0;
    end else begin
      v1_q     <= fif.da_valid;
      match1_q <= match;
      bcast1_q <= cfg_bcast_en && (fif.da_addr == BCAST_ADDR);
      pause1_q <= PAUSE_EN && (fif.da_addr == PAUSE_ADDR);
      hash1_q  <= fif.da_addr[40] && hash_table[hash_fold(fif.da_addr)];
      mall1_q  <= fif.da_addr[40] && cfg_mcast_all;
      prom1_q  <= cfg_promisc;
    end
  end

  // Stage 2: priority decision
  logic [IDX_W-1:0] low_idx;
  logic             low_found;
  match_class_e     cls_d;
  logic [IDX_W-1:0] idx_d;

  always_comb begin
    low_idx   = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < NUM_UCAST; i++) begin
      if (match1_q[i] && !low_found) begin
        low_found = 1'b1;
        low_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    cls_d = CLS_NONE;
    idx_d = '0;
    if (v1_q) begin
      if (bcast1_q)       cls_d = CLS_BCAST;
      else if (pause1_q)  cls_d = CLS_PAUSE;
      else if (low_found) begin
        cls_d = CLS_UCAST;
        idx_d = low_idx;
      end
      else if (hash1_q)   cls_d = CLS_MCAST_HASH;
      else if (mall1_q)   cls_d = CLS_MCAST_ALL;
      else if (prom1_q)   cls_d = CLS_PROMISC;
    end
  end

  logic             res_valid_q, res_accept_q;
  match_class_e     res_class_q;
  logic [IDX_W-1:0] res_idx_q;
  logic [CNT_W-1:0] drop_q;

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid_q  <= 1'b0;
      res_accept_q <= 1'b0;
      res_class_q  <= CLS_NONE;
      res_idx_q    <= '0;
    end else begin
      res_valid_q  <= v1_q;
      res_accept_q <= v1_q && (cls_d != CLS_NONE);
      res_class_q  <= cls_d;
      res_idx_q    <= idx_d;
    end
  end

  always_ff @(posedge rxclk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= '0;
    end else if (cnt_clr) begin
      drop_q <= '0;
    end else if (res_valid_q && !res_accept_q && (drop_q != '1)) begin
      drop_q <= drop_q + CNT_W'(1);
    end
  end

  assign fif.res_valid  = res_valid_q;
  assign fif.res_accept = res_accept_q;
  assign fif.res_class  = res_class_q;
  assign fif.res_idx    = res_idx_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_rx_addr_filter.sv
// Self-checking bench for rx_addr_filter: directed scenarios followed by
// randomized traffic, checked against a rule-level reference model.
module tb_rx_addr_filter;

  localparam int NU = 4;

  logic        rxclk = 1'b0;
  logic        reset_n;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [47:0] cfg_addr;
  logic        cfg_ent_en;
  logic        cfg_promisc;
  logic        cfg_bcast_en;
  logic        cfg_mcast_all;
  logic [63:0] hash_table;
  logic        cnt_clr;
  logic [3:0]  drop_count;

  rx_addr_filter_if #(.IDX_W(2)) fif ();

  rx_addr_filter #(
    .NUM_UCAST (NU),
    .CNT_W     (4)
  ) dut (
    .rxclk         (rxclk),
    .reset_n       (reset_n),
    .cfg_we        (cfg_we),
    .cfg_idx       (cfg_idx),
    .cfg_addr      (cfg_addr),
    .cfg_ent_en    (cfg_ent_en),
    .cfg_promisc   (cfg_promisc),
    .cfg_bcast_en  (cfg_bcast_en),
    .cfg_mcast_all (cfg_mcast_all),
    .hash_table    (hash_table),
    .cnt_clr       (cnt_clr),
    .fif           (fif.master),
    .drop_count    (drop_count)
  );

  always #5 rxclk = ~rxclk;

  typedef struct packed {
    logic       valid;
    logic [2:0] cls;
    logic [1:0] idx;
  } exp_t;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [47:0] m_addr [NU];
  logic        m_en   [NU];
  int          cnt_m;
  exp_t        in_s1, on_out;

  localparam logic [47:0] UC2   = 48'h001B213A4C5D;
  localparam logic [47:0] MISS  = 48'h00AABBCCDDEE;
  localparam logic [47:0] PAUSE = 48'h0180C2000001;
  localparam logic [47:0] MC1   = 48'h01005E000001;

  function automatic logic [5:0] model_hash(input logic [47:0] a);
    logic [5:0] h = '0;
    for (int i = 0; i < 48; i++) h[i % 6] ^= a[i];
    return h;
  endfunction

  function automatic logic [2:0] model_class(input logic [47:0] a, output logic [1:0] ui);
    logic hit = 1'b0;
    ui = '0;
    if (a == 48'hFFFF_FFFF_FFFF && cfg_bcast_en) return 3'd2;
    if (a == PAUSE) return 3'd3;
    for (int i = NU - 1; i >= 0; i--) begin
      if (m_en[i] && m_addr[i] == a) begin
        hit = 1'b1;
        ui  = 2'(i);
      end
    end
    if (hit) return 3'd1;
    if (a[40] && hash_table[model_hash(a)]) return 3'd4;
    if (a[40] && cfg_mcast_all) return 3'd5;
    if (cfg_promisc) return 3'd6;
    return 3'd0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NU; i++) begin
      m_addr[i] = '0;
      m_en[i]   = 1'b0;
    end
    cnt_m  = 0;
    in_s1  = '0;
    on_out = '0;
  endtask

  // One clock: drive a frame (or idle), advance the model, check the outputs
  task automatic step(input logic v, input logic [47:0] a);
    exp_t cur;
    fif.da_valid = v;
    fif.da_addr  = a;
    cur.valid    = v;
    cur.cls      = model_class(a, cur.idx);
    if (cnt_clr) cnt_m = 0;
    else if (on_out.valid && on_out.cls == 3'd0 && cnt_m != 15) cnt_m++;
    if (cfg_we) begin
      m_addr[cfg_idx] = cfg_addr;
      m_en[cfg_idx]   = cfg_ent_en;
    end
    @(posedge rxclk);
    #1;
    on_out = in_s1;
    in_s1  = cur;
    fif.da_valid = 1'b0;
    cfg_we       = 1'b0;
    cnt_clr      = 1'b0;
    chk("res_valid", 64'(fif.res_valid), 64'(on_out.valid));
    if (on_out.valid) begin
      chk("res_accept", 64'(fif.res_accept), 64'(on_out.cls != 3'd0));
      chk("res_class", 64'(fif.res_class), 64'(on_out.cls));
      if (on_out.cls == 3'd1) chk("res_idx", 64'(fif.res_idx), 64'(on_out.idx));
    end
    chk("drop_count", 64'(drop_count), 64'(cnt_m));
  endtask

  task automatic write_entry(input logic [1:0] i, input logic [47:0] a, input logic en);
    cfg_we = 1'b1; cfg_idx = i; cfg_addr = a; cfg_ent_en = en;
    step(1'b0, '0);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, 64'(fif.res_valid), 64'd0);
    chk({tag, "_accept"}, 64'(fif.res_accept), 64'd0);
    chk({tag, "_class"}, 64'(fif.res_class), 64'd0);
    chk({tag, "_idx"}, 64'(fif.res_idx), 64'd0);
    chk({tag, "_drop"}, 64'(drop_count), 64'd0);
  endtask

  initial begin
    logic [47:0] ra;
    logic [1:0]  ri;
    reset_n = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_ent_en = 1'b0;
    cfg_promisc = 1'b0; cfg_bcast_en = 1'b0; cfg_mcast_all = 1'b0;
    hash_table = '0; cnt_clr = 1'b0;
    fif.da_valid = 1'b0; fif.da_addr = '0;
    model_reset();
    repeat (2) @(posedge rxclk);
    #1 reset_n = 1'b1;
    check_idle_outputs("reset");

    // Unicast hit on entry 2, then a miss
    write_entry(2'd2, UC2, 1'b1);
    step(1'b1, UC2);
    step(1'b1, MISS);
    repeat (3) step(1'b0, '0);
    chk("miss_drop", 64'(drop_count), 64'd1);

    // Broadcast with and without bcast_en
    cfg_bcast_en = 1'b1;
    step(1'b1, 48'hFFFF_FFFF_FFFF);
    cfg_bcast_en = 1'b0;
    step(1'b1, 48'hFFFF_FFFF_FFFF);

    // PAUSE, hash bin, mcast_all
    step(1'b1, PAUSE);
    hash_table = 64'd1 << model_hash(MC1);
    step(1'b1, MC1);
    hash_table = '0; cfg_mcast_all = 1'b1;
    step(1'b1, MC1);
    cfg_mcast_all = 1'b0;
    repeat (2) step(1'b0, '0);

    // Back-to-back frames, then a same-cycle overwrite of the matched entry
    step(1'b1, UC2);
    step(1'b1, PAUSE);
    step(1'b1, MISS);
    cfg_we = 1'b1; cfg_idx = 2'd2; cfg_addr = 48'h0022_3344_5566; cfg_ent_en = 1'b1;
    step(1'b1, UC2);
    step(1'b1, UC2);
    repeat (2) step(1'b0, '0);

    // Drop counter saturation and clear-vs-increment
    cnt_clr = 1'b1;
    step(1'b0, '0);
    repeat (19) step(1'b1, MISS);
    repeat (2) step(1'b0, '0);
    chk("drop_sat", 64'(drop_count), 64'd15);
    step(1'b1, MISS);
    step(1'b0, '0);
    cnt_clr = 1'b1;
    step(1'b0, '0);
    chk("clr_over_inc", 64'(drop_count), 64'd0);

    // Reset one cycle after a frame: verdict must vanish, table cleared
    write_entry(2'd0, UC2, 1'b1);
    step(1'b1, UC2);
    #3 reset_n = 1'b0;
    #1 check_idle_outputs("mid_reset");
    model_reset();
    @(posedge rxclk);
    @(posedge rxclk);
    #1 reset_n = 1'b1;
    check_idle_outputs("post_reset");
    repeat (3) step(1'b0, '0);
    step(1'b1, UC2);
    repeat (2) step(1'b0, '0);

    // Randomized traffic and configuration
    for (int n = 0; n < 400; n++) begin
      if (n % 16 == 0) begin
        cfg_promisc   = ($urandom_range(0, 3) == 0);
        cfg_bcast_en  = $urandom_range(0, 1) == 1;
        cfg_mcast_all = ($urandom_range(0, 3) == 0);
        hash_table    = {$urandom, $urandom} & {$urandom, $urandom};
      end
      if ($urandom_range(0, 7) == 0) begin
        cfg_we     = 1'b1;
        cfg_idx    = 2'($urandom_range(0, NU - 1));
        ri         = 2'($urandom_range(0, NU - 1));
        cfg_addr   = ($urandom_range(0, 2) == 0) ? m_addr[ri] : {16'($urandom), $urandom};
        cfg_ent_en = ($urandom_range(0, 3) != 0);
      end
      cnt_clr = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 5))
        0:       ra = m_addr[$urandom_range(0, NU - 1)];
        1:       ra = 48'hFFFF_FFFF_FFFF;
        2:       ra = PAUSE;
        3:       ra = {16'($urandom), $urandom} | 48'h0100_0000_0000;
        4:       ra = {16'($urandom), $urandom} & ~48'h0100_0000_0000;
        default: ra = {16'($urandom), $urandom};
      endcase
      step($urandom_range(0, 3) != 0, ra);
    end
    repeat (3) step(1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
